// File: rtl/raster_scan.sv
`default_nettype none
// ============================================================================
// Module      : raster_scan
// Description : Flat-shaded triangle rasterizer. Latches one triangle and
//               computes its clipped bounding box. It then walks the box in
//               row-major order, one pixel per cycle, and emits a fragment
//               for every pixel the triangle covers. The fragment output
//               uses a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module raster_scan #(
    parameter int COORD_WIDTH = 16,
    parameter int COLOR_WIDTH = 16,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COORD_WIDTH-1:0] vertexes [3][3],
    input  logic [COLOR_WIDTH-1:0] colors,
    output logic                   frag_valid,
    input  logic                   frag_ready,
    output logic [COORD_WIDTH-1:0] frag_x,
    output logic [COORD_WIDTH-1:0] frag_y,
    output logic [COLOR_WIDTH-1:0] frag_color,
    output logic                   busy,
    output logic                   done
);

    // Every coordinate, difference and edge value lives at this width.
    // Two (COORD_WIDTH+1)-bit differences multiplied and then subtracted
    // cannot overflow it.
    localparam int EW = 2 * COORD_WIDTH + 3;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_SCAN   = 2'd2;
    localparam logic [1:0] c_FINISH = 2'd3;

    localparam logic signed [EW-1:0] c_ZERO = '0;
    localparam logic signed [EW-1:0] c_ONE  = EW'(1);
    localparam logic signed [EW-1:0] c_XLIM = EW'(SCREEN_W - 1);
    localparam logic signed [EW-1:0] c_YLIM = EW'(SCREEN_H - 1);

    logic [1:0]             r_state;
    logic signed [EW-1:0]   r_vx [3];
    logic signed [EW-1:0]   r_vy [3];
    logic [COLOR_WIDTH-1:0] r_color;
    logic signed [EW-1:0]   r_xmin, r_xmax, r_ymin, r_ymax;
    logic signed [EW-1:0]   r_cx, r_cy;
    logic                   r_scan_end;

    logic signed [EW-1:0]   w_min_x, w_max_x, w_min_y, w_max_y;
    logic signed [EW-1:0]   w_bxmin, w_bxmax, w_bymin, w_bymax;
    logic signed [EW-1:0]   w_area;
    logic signed [EW-1:0]   w_e [3];
    logic [2:0]             w_pos, w_neg;
    logic                   w_empty, w_inside, w_advance, w_at_end, w_out_free;

    // The z coordinate plays no part in flat 2D coverage.
    wire w_unused_z = ^{vertexes[0][2], vertexes[1][2], vertexes[2][2]};

    // Unclipped bounding box of the latched vertices
    always_comb begin
        w_min_x = r_vx[0];
        w_max_x = r_vx[0];
        w_min_y = r_vy[0];
        w_max_y = r_vy[0];
        for (int i = 1; i < 3; i++) begin
            if (r_vx[i] < w_min_x) w_min_x = r_vx[i];
            if (r_vx[i] > w_max_x) w_max_x = r_vx[i];
            if (r_vy[i] < w_min_y) w_min_y = r_vy[i];
            if (r_vy[i] > w_max_y) w_max_y = r_vy[i];
        end
    end

    // Clip the box to the screen. A triangle that lies fully off screen
    // gives an inverted box, and that box counts as empty.
    assign w_bxmin = (w_min_x < c_ZERO) ? c_ZERO : w_min_x;
    assign w_bxmax = (w_max_x > c_XLIM) ? c_XLIM : w_max_x;
    assign w_bymin = (w_min_y < c_ZERO) ? c_ZERO : w_min_y;
    assign w_bymax = (w_max_y > c_YLIM) ? c_YLIM : w_max_y;
    assign w_empty = (w_bxmin > w_bxmax) || (w_bymin > w_bymax);

    // Doubled signed area; zero means the three vertices are collinear
    assign w_area = (r_vx[1] - r_vx[0]) * (r_vy[2] - r_vy[0])
                  - (r_vy[1] - r_vy[0]) * (r_vx[2] - r_vx[0]);

    // Each edge function is evaluated directly at the current scan pixel
    for (genvar i = 0; i < 3; i++) begin : g_edge
        localparam int B = (i + 1) % 3;
        assign w_e[i]   = (r_cx - r_vx[i]) * (r_vy[B] - r_vy[i])
                        - (r_cy - r_vy[i]) * (r_vx[B] - r_vx[i]);
        assign w_pos[i] = ~w_e[i][EW-1];
        assign w_neg[i] = w_e[i][EW-1] | (w_e[i] == c_ZERO);
    end

    // Either winding counts as inside, and pixels on an edge are included
    assign w_inside   = (&w_pos) | (&w_neg);
    assign w_out_free = ~frag_valid | frag_ready;
    assign w_advance  = (r_state == c_SCAN) && !r_scan_end && w_out_free;
    assign w_at_end   = (r_cx == r_xmax) && (r_cy == r_ymax);

    assign busy = (r_state != c_IDLE);
    assign done = (r_state == c_FINISH);

    // Control FSM, triangle latch, scan cursor and fragment output register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_scan_end <= 1'b0;
            frag_valid <= 1'b0;
            frag_x     <= '0;
            frag_y     <= '0;
            frag_color <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 3; i++) begin
                            r_vx[i] <= EW'($signed(vertexes[i][0]));
                            r_vy[i] <= EW'($signed(vertexes[i][1]));
                        end
                        r_color <= colors;
                        r_state <= c_SETUP;
                    end
                end
                c_SETUP: begin
                    r_xmin     <= w_bxmin;
                    r_xmax     <= w_bxmax;
                    r_ymin     <= w_bymin;
                    r_ymax     <= w_bymax;
                    r_cx       <= w_bxmin;
                    r_cy       <= w_bymin;
                    r_scan_end <= 1'b0;
                    if (w_empty || (w_area == c_ZERO)) begin
                        r_state <= c_FINISH;
                    end else begin
                        r_state <= c_SCAN;
                    end
                end
                c_SCAN: begin
                    if (frag_valid && frag_ready) begin
                        frag_valid <= 1'b0;
                    end
                    if (w_advance) begin
                        if (w_inside) begin
                            frag_valid <= 1'b1;
                            frag_x     <= r_cx[COORD_WIDTH-1:0];
                            frag_y     <= r_cy[COORD_WIDTH-1:0];
                            frag_color <= r_color;
                        end
                        if (w_at_end) begin
                            r_scan_end <= 1'b1;
                        end else if (r_cx == r_xmax) begin
                            r_cx <= r_xmin;
                            r_cy <= r_cy + c_ONE;
                        end else begin
                            r_cx <= r_cx + c_ONE;
                        end
                    end
                    if (r_scan_end && w_out_free) begin
                        r_state <= c_FINISH;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_raster_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_raster_scan
// Description : Self-checking bench for raster_scan. It runs directed
//               triangles and random triangles against a reference coverage
//               model computed directly from the edge-function rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_raster_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        frag_ready;
    logic [15:0] vertexes [3][3];
    logic [15:0] colors;
    wire         frag_valid;
    wire  [15:0] frag_x;
    wire  [15:0] frag_y;
    wire  [15:0] frag_color;
    wire         busy;
    wire         done;

    raster_scan #(
        .COORD_WIDTH(16),
        .COLOR_WIDTH(16),
        .SCREEN_W   (640),
        .SCREEN_H   (480)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .vertexes  (vertexes),
        .colors    (colors),
        .frag_valid(frag_valid),
        .frag_ready(frag_ready),
        .frag_x    (frag_x),
        .frag_y    (frag_y),
        .frag_color(frag_color),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] got_q [$];
    logic [15:0] gcol_q [$];
    logic [31:0] exp_q [$];
    int   stall_err, done_cnt, first_frag, done_at, timed_out;
    logic after_busy, after_done;

    // Directed triangle (0,0),(3,0),(0,3) listed in row-major order
    int ex [10] = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0};
    int ey [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};

    task automatic set_verts(input int x0, y0, x1, y1, x2, y2);
        vertexes[0][0] = 16'(x0); vertexes[0][1] = 16'(y0);
        vertexes[1][0] = 16'(x1); vertexes[1][1] = 16'(y1);
        vertexes[2][0] = 16'(x2); vertexes[2][1] = 16'(y2);
        for (int i = 0; i < 3; i++) vertexes[i][2] = 16'($urandom);
    endtask

    // Reference coverage: every pixel of the clipped box where all three
    // edge functions share a sign (zero allowed), listed in row-major order
    task automatic model_tri(input int x0, y0, x1, y1, x2, y2);
        longint ax [3];
        longint ay [3];
        longint a2, e;
        int     xmn, xmx, ymn, ymx, npos, nneg;
        exp_q.delete();
        ax[0] = x0; ax[1] = x1; ax[2] = x2;
        ay[0] = y0; ay[1] = y1; ay[2] = y2;
        xmn = x0; xmx = x0; ymn = y0; ymx = y0;
        if (x1 < xmn) xmn = x1;
        if (x2 < xmn) xmn = x2;
        if (x1 > xmx) xmx = x1;
        if (x2 > xmx) xmx = x2;
        if (y1 < ymn) ymn = y1;
        if (y2 < ymn) ymn = y2;
        if (y1 > ymx) ymx = y1;
        if (y2 > ymx) ymx = y2;
        if (xmn < 0) xmn = 0;
        if (ymn < 0) ymn = 0;
        if (xmx > 639) xmx = 639;
        if (ymx > 479) ymx = 479;
        a2 = (ax[1] - ax[0]) * (ay[2] - ay[0]) - (ay[1] - ay[0]) * (ax[2] - ax[0]);
        if (a2 == 0) return;
        for (int y = ymn; y <= ymx; y++) begin
            for (int x = xmn; x <= xmx; x++) begin
                npos = 0; nneg = 0;
                for (int k = 0; k < 3; k++) begin
                    e = (x - ax[k]) * (ay[(k + 1) % 3] - ay[k])
                      - (y - ay[k]) * (ax[(k + 1) % 3] - ax[k]);
                    if (e >= 0) npos++;
                    if (e <= 0) nneg++;
                end
                if (npos == 3 || nneg == 3) exp_q.push_back({16'(x), 16'(y)});
            end
        end
    endtask

    // Runs one triangle from an IDLE negedge. Mode 0 holds ready high,
    // mode 1 toggles it, and mode 2 randomizes both ready and spurious
    // starts while busy. It stops one cycle after done, after stop_after
    // fragments, or when the cycle budget runs out.
    task automatic drive_tri(input int x0, y0, x1, y1, x2, y2,
                             input logic [15:0] col, input int mode,
                             input int stop_after);
        logic        stalled;
        logic [15:0] px, py, pc;
        stalled = 1'b0;
        px = '0; py = '0; pc = '0;
        got_q.delete(); gcol_q.delete();
        stall_err = 0; done_cnt = 0; first_frag = -1; done_at = -1; timed_out = 1;
        set_verts(x0, y0, x1, y1, x2, y2);
        colors = col;
        start  = 1'b1;
        for (int n = 1; n <= 6000; n++) begin
            @(negedge clk);
            if (done_at >= 0) begin
                after_busy = busy; after_done = done; timed_out = 0; start = 1'b0;
                break;
            end
            if (n == 1) begin
                set_verts($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
                colors = 16'($urandom);
            end
            start = (mode == 2) ? (busy && ($urandom_range(0, 1) == 1)) : 1'b0;
            if (stalled && !(frag_valid === 1'b1 && frag_x === px &&
                             frag_y === py && frag_color === pc)) stall_err++;
            case (mode)
                0:       frag_ready = 1'b1;
                1:       frag_ready = n[0];
                default: frag_ready = ($urandom_range(0, 1) == 1);
            endcase
            if (frag_valid === 1'b1 && frag_ready) begin
                got_q.push_back({frag_x, frag_y});
                gcol_q.push_back(frag_color);
                if (first_frag < 0) first_frag = n;
            end
            stalled = (frag_valid === 1'b1) && !frag_ready;
            px = frag_x; py = frag_y; pc = frag_color;
            if (done === 1'b1) begin done_cnt++; done_at = n; end
            if (stop_after > 0 && got_q.size() == stop_after) begin
                timed_out = 0; start = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; frag_ready = 1'b1;
        set_verts(0, 0, 3, 0, 0, 3);
        colors = 16'hF800;
        repeat (3) @(negedge clk);
        tests++;
        if (frag_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: valid=%b busy=%b done=%b, want 0 0 0", frag_valid, busy, done);
        end
        tests++;
        if (frag_x !== 16'h0 || frag_y !== 16'h0 || frag_color !== 16'h0) begin
            fails++;
            $display("FAIL reset_data: x=%h y=%h c=%h, want 0 0 0", frag_x, frag_y, frag_color);
        end
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b, want 0", busy);
        end
    endtask

    // Compares the collected fragments with the directed 10-pixel list
    task automatic test_basic(input string name, input int x0, y0, x1, y1, x2, y2, input int mode);
        int bad;
        drive_tri(x0, y0, x1, y1, x2, y2, 16'hF800, mode, 0);
        tests++;
        if (timed_out != 0 || got_q.size() != 10) begin
            fails++;
            $display("FAIL %s_count: got %0d frags timeout=%0d, want 10", name, got_q.size(), timed_out);
        end
        bad = -1;
        for (int i = 0; i < 10 && i < got_q.size(); i++)
            if (bad < 0 && (got_q[i] !== {16'(ex[i]), 16'(ey[i])} || gcol_q[i] !== 16'hF800)) bad = i;
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s_order: frag %0d got xy=%h c=%h, want x=%0d y=%0d c=f800",
                     name, bad, got_q[bad], gcol_q[bad], ex[bad], ey[bad]);
        end
        tests++;
        if (first_frag != 3) begin
            fails++;
            $display("FAIL %s_latency: first frag at cycle %0d, want 3", name, first_frag);
        end
        tests++;
        if (done_cnt != 1 || after_done !== 1'b0 || after_busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_done: pulses=%0d after_done=%b after_busy=%b, want 1 0 0",
                     name, done_cnt, after_done, after_busy);
        end
        tests++;
        if (stall_err != 0) begin
            fails++;
            $display("FAIL %s_stall: %0d unstable stall cycles, want 0", name, stall_err);
        end
    endtask

    task automatic test_degenerate;
        drive_tri(0, 0, 2, 2, 4, 4, 16'h1234, 0, 0);
        tests++;
        if (timed_out != 0 || got_q.size() != 0 || done_at != 2) begin
            fails++;
            $display("FAIL collinear: frags=%0d done_at=%0d timeout=%0d, want 0 2 0",
                     got_q.size(), done_at, timed_out);
        end
        drive_tri(-10, -10, -5, -10, -10, -5, 16'h1234, 0, 0);
        tests++;
        if (timed_out != 0 || got_q.size() != 0 || done_at != 2) begin
            fails++;
            $display("FAIL offscreen: frags=%0d done_at=%0d timeout=%0d, want 0 2 0",
                     got_q.size(), done_at, timed_out);
        end
    endtask

    task automatic test_clip;
        int over;
        model_tri(638, 0, 645, 0, 638, 7);
        drive_tri(638, 0, 645, 0, 638, 7, 16'h07E0, 0, 0);
        over = 0;
        foreach (got_q[i]) if (got_q[i][31:16] > 16'd639) over++;
        tests++;
        if (timed_out != 0 || got_q.size() != 15 || over != 0) begin
            fails++;
            $display("FAIL clip_count: frags=%0d over639=%0d timeout=%0d, want 15 0 0",
                     got_q.size(), over, timed_out);
        end
        tests++;
        if (got_q != exp_q) begin
            fails++;
            $display("FAIL clip_list: got %0d frags, model gives %0d or order differs",
                     got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        drive_tri(0, 0, 3, 0, 0, 3, 16'hF800, 0, 3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (frag_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL midreset: valid=%b busy=%b done=%b, want 0 0 0", frag_valid, busy, done);
        end
        reset = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (done !== 1'b0 || frag_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL midreset_quiet: %0d active cycles after abort, want 0", bad);
        end
        test_basic("restart", 0, 0, 3, 0, 0, 3, 0);
    endtask

    task automatic test_back_to_back;
        drive_tri(0, 0, 3, 0, 0, 3, 16'hF800, 0, 0);
        tests++;
        if (got_q.size() != 10 || done_cnt != 1) begin
            fails++;
            $display("FAIL b2b_first: frags=%0d done=%0d, want 10 1", got_q.size(), done_cnt);
        end
        model_tri(1, 1, 4, 1, 1, 4);
        drive_tri(1, 1, 4, 1, 1, 4, 16'h07E0, 0, 0);
        tests++;
        if (first_frag != 3 || got_q != exp_q || done_cnt != 1) begin
            fails++;
            $display("FAIL b2b_second: first=%0d frags=%0d/%0d done=%0d, want 3 %0d 1",
                     first_frag, got_q.size(), exp_q.size(), done_cnt, exp_q.size());
        end
    endtask

    task automatic test_random;
        int c [6];
        int bad_col;
        logic [15:0] col;
        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 3; k++) begin
                c[2*k]   = (t % 4 == 3 ? 625 : 0) + int'($urandom_range(0, 24)) - 6;
                c[2*k+1] = (t % 5 == 4 ? 465 : 0) + int'($urandom_range(0, 24)) - 6;
            end
            col = 16'($urandom);
            model_tri(c[0], c[1], c[2], c[3], c[4], c[5]);
            drive_tri(c[0], c[1], c[2], c[3], c[4], c[5], col, 2, 0);
            bad_col = 0;
            foreach (gcol_q[i]) if (gcol_q[i] !== col) bad_col++;
            tests++;
            if (timed_out != 0 || got_q != exp_q || done_cnt != 1) begin
                fails++;
                $display("FAIL rand%0d_frags: (%0d,%0d)(%0d,%0d)(%0d,%0d) got %0d model %0d done=%0d to=%0d",
                         t, c[0], c[1], c[2], c[3], c[4], c[5], got_q.size(), exp_q.size(),
                         done_cnt, timed_out);
            end
            tests++;
            if (bad_col != 0 || stall_err != 0) begin
                fails++;
                $display("FAIL rand%0d_hold: color errors=%0d stall errors=%0d, want 0 0",
                         t, bad_col, stall_err);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; frag_ready = 1'b0; colors = '0;
        set_verts(0, 0, 0, 0, 0, 0);
        test_reset();
        test_basic("basic", 0, 0, 3, 0, 0, 3, 0);
        test_basic("winding", 0, 0, 0, 3, 3, 0, 0);
        test_degenerate();
        test_basic("toggle", 0, 0, 3, 0, 0, 3, 1);
        test_clip();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
